// File: rtl/key_event_if.sv
// Event output channel of key_event_ctrl: valid/ready head-of-FIFO plus drop status.
interface key_event_if #(
  parameter int KW = 2
) ();
  logic          evt_valid;
  logic          evt_ready;
  logic [KW-1:0] evt_key;
  logic [1:0]    evt_type;
  logic [7:0]    drop_cnt;

  modport master (output evt_valid, evt_key, evt_type, drop_cnt, input evt_ready);
  modport slave  (input evt_valid, evt_key, evt_type, drop_cnt, output evt_ready);
endinterface

// File: rtl/key_event_ctrl.sv
// Front-panel key event classifier: per-key SHORT/LONG/REPEAT FSMs on a shared
// ms timebase, one pending slot per key, round-robin arbiter into an event FIFO.
module key_event_ctrl #(
  parameter int NUM_KEYS   = 4,
  parameter int CLK_HZ     = 50000000,
  parameter int LONG_MS    = 1000,
  parameter int REPEAT_MS  = 200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_press,
  input  logic [NUM_KEYS-1:0] key_release,
  key_event_if.master         evt
);
  localparam int KW = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1;
  localparam int TP = CLK_HZ / 1000;
  localparam int TW = (TP > 1) ? $clog2(TP) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {EV_NONE = 2'b00, EV_SHORT = 2'b01, EV_LONG = 2'b10, EV_REPEAT = 2'b11} ev_e;
  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} kst_e;

  logic [TW-1:0]              tick_q;
  logic                       ms_tick;
  logic [NUM_KEYS-1:0]        pend_v, grant_vec, drop_vec;
  logic [NUM_KEYS-1:0][1:0]   pend_t;
  logic [KW-1:0]              rr_q, grant_idx, idx;
  logic                       grant_found, can_push, push, pop, full;
  logic [KW+1:0]              mem_q [FIFO_DEPTH];
  logic [AW-1:0]              wr_q, rd_q;
  logic [AW:0]                cnt_q;
  logic [7:0]                 drop_q, drop_d;
  logic [3:0]                 ndrop;
  logic [8:0]                 dsum;

  assign ms_tick = (tick_q == TW'(TP - 1));

  // Free-running ms timebase
  always_ff @(posedge clk)
    if (!rst_n)       tick_q <= '0;
    else if (ms_tick) tick_q <= '0;
    else              tick_q <= tick_q + 1'b1;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    kst_e        st_q;
    logic [15:0] hold_q, rep_q;
    logic        pv_q, rs;
    logic [1:0]  pt_q, rt;

    // Event raised this cycle, decided from current state; release beats a same-cycle tick
    always_comb begin
      rs = 1'b0;
      rt = EV_NONE;
      case (st_q)
        S_PRESSED:
          if (key_release[k]) begin
            rs = 1'b1; rt = EV_SHORT;
          end else if (ms_tick && hold_q == 16'(LONG_MS - 1)) begin
            rs = 1'b1; rt = EV_LONG;
          end
        S_HELD:
          if (!key_release[k] && ms_tick && rep_q == 16'(REPEAT_MS - 1)) begin
            rs = 1'b1; rt = EV_REPEAT;
          end
        default: ;
      endcase
    end

    // Per-key press/hold/repeat FSM
    always_ff @(posedge clk)
      if (!rst_n) begin
        st_q   <= S_IDLE;
        hold_q <= '0;
        rep_q  <= '0;
      end else begin
        case (st_q)
          S_IDLE:
            if (key_press[k]) begin
              st_q   <= S_PRESSED;
              hold_q <= '0;
            end
          S_PRESSED:
            if (key_release[k]) st_q <= S_IDLE;
            else if (ms_tick) begin
              if (hold_q == 16'(LONG_MS - 1)) begin
                st_q  <= S_HELD;
                rep_q <= '0;
              end else hold_q <= hold_q + 16'd1;
            end
          S_HELD:
            if (key_release[k]) st_q <= S_IDLE;
            else if (ms_tick) begin
              if (rep_q == 16'(REPEAT_MS - 1)) rep_q <= '0;
              else                              rep_q <= rep_q + 16'd1;
            end
          default: st_q <= S_IDLE;
        endcase
      end

    // Pending slot: a granted slot can be refilled in the same cycle
    always_ff @(posedge clk)
      if (!rst_n) begin
        pv_q <= 1'b0;
        pt_q <= EV_NONE;
      end else if (rs && (!pv_q || grant_vec[k])) begin
        pv_q <= 1'b1;
        pt_q <= rt;
      end else if (grant_vec[k]) begin
        pv_q <= 1'b0;
      end

    assign pend_v[k]   = pv_q;
    assign pend_t[k]   = pt_q;
    assign drop_vec[k] = rs && pv_q && !grant_vec[k];
  end

  assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop      = evt.evt_valid && evt.evt_ready;
  assign can_push = !full || pop;
  assign push     = grant_found;

  // Round-robin search for the first pending slot at or after rr_q
  always_comb begin
    grant_vec   = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      idx = KW'((int'(rr_q) + i) % NUM_KEYS);
      if (!grant_found && can_push && pend_v[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
    if (grant_found) grant_vec[grant_idx] = 1'b1;
  end

  // Round-robin pointer moves past the winner only
  always_ff @(posedge clk)
    if (!rst_n)           rr_q <= '0;
    else if (grant_found) rr_q <= (grant_idx == KW'(NUM_KEYS - 1)) ? '0 : grant_idx + 1'b1;

  // FIFO storage, entry = {key, type}
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {grant_idx, pend_t[grant_idx]};

  // FIFO pointers and occupancy
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end

  // Saturating count of events lost to an occupied slot
  always_comb begin
    ndrop = '0;
    for (int k = 0; k < NUM_KEYS; k++) ndrop = ndrop + {3'b0, drop_vec[k]};
    dsum   = {1'b0, drop_q} + {5'b0, ndrop};
    drop_d = dsum[8] ? 8'hFF : dsum[7:0];
  end

  // Drop counter register
  always_ff @(posedge clk)
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;

  assign evt.evt_valid = (cnt_q != '0);
  assign evt.evt_key   = evt.evt_valid ? mem_q[rd_q][KW+1:2] : '0;
  assign evt.evt_type  = evt.evt_valid ? mem_q[rd_q][1:0]    : 2'b00;
  assign evt.drop_cnt  = drop_q;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed scenarios plus random traffic, checked every
// cycle against a queue-based behavioural model of the event stream.
module tb_key_event_ctrl;
  localparam int NK = 4, CLK_HZ = 10000, LM = 5, RM = 2, FD = 4, TP = CLK_HZ / 1000, KW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] kp = '0, kr = '0;

  key_event_if #(.KW(KW)) eif ();

  key_event_ctrl #(.NUM_KEYS(NK), .CLK_HZ(CLK_HZ), .LONG_MS(LM), .REPEAT_MS(RM), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .key_press(kp), .key_release(kr), .evt(eif)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [KW-1:0] key; logic [1:0] typ; } ev_t;
  ev_t        mq[$];
  bit         mpv[NK];
  logic [1:0] mpt[NK];
  bit         mheld[NK];
  int         mt[NK];       // ms ticks seen since press
  int         mrr, mdrop, mtcnt;
  int         n_short = 0, n_long = 0, n_rep = 0;

  task automatic model_step();
    bit tick, pop, can;
    int g, idx;
    bit rs[NK];
    logic [1:0] rt[NK];
    ev_t e;
    if (!rst_n) begin
      mq.delete();
      for (int k = 0; k < NK; k++) begin mpv[k] = 0; mpt[k] = 0; mheld[k] = 0; mt[k] = 0; end
      mrr = 0; mdrop = 0; mtcnt = 0;
      return;
    end
    tick  = (mtcnt == TP - 1);
    mtcnt = (mtcnt + 1) % TP;
    for (int k = 0; k < NK; k++) begin
      rs[k] = 0; rt[k] = 2'b00;
      if (mheld[k]) begin
        if (kr[k]) begin
          if (mt[k] < LM) begin rs[k] = 1; rt[k] = 2'b01; end
          mheld[k] = 0;
        end else if (tick) begin
          mt[k]++;
          if (mt[k] == LM) begin rs[k] = 1; rt[k] = 2'b10; end
          else if (mt[k] > LM && (mt[k] - LM) % RM == 0) begin rs[k] = 1; rt[k] = 2'b11; end
        end
      end else if (kp[k]) begin
        mheld[k] = 1; mt[k] = 0;
      end
    end
    pop = (mq.size() > 0) && eif.evt_ready;
    can = (mq.size() < FD) || pop;
    g = -1;
    if (can)
      for (int i = 0; i < NK; i++) begin
        idx = (mrr + i) % NK;
        if (g < 0 && mpv[idx]) g = idx;
      end
    if (pop) begin
      e = mq.pop_front();
      case (e.typ)
        2'b01: n_short++;
        2'b10: n_long++;
        default: n_rep++;
      endcase
    end
    if (g >= 0) begin
      e.key = KW'(g); e.typ = mpt[g];
      mq.push_back(e);
      mpv[g] = 0;
      mrr = (g + 1) % NK;
    end
    for (int k = 0; k < NK; k++)
      if (rs[k]) begin
        if (mpv[k]) begin if (mdrop < 255) mdrop++; end
        else begin mpv[k] = 1; mpt[k] = rt[k]; end
      end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  ev_t        c_h;
  logic       c_v;
  logic [12:0] c_act, c_exp;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      c_v = (mq.size() > 0);
      c_h = c_v ? mq[0] : '0;
      c_act = {eif.evt_valid, eif.evt_key, eif.evt_type, eif.drop_cnt};
      c_exp = {c_v, c_h.key, c_h.typ, 8'(mdrop)};
      checks++;
      if (c_act !== c_exp) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t got v=%b key=%0d type=%0d drop=%0d exp v=%b key=%0d type=%0d drop=%0d",
                 $time, eif.evt_valid, eif.evt_key, eif.evt_type, eif.drop_cnt, c_v, c_h.key, c_h.typ, mdrop);
      end
    end
  end

  // ---------------- literal checks / stimulus helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [NK-1:0] p, input logic [NK-1:0] r);
    kp = p; kr = r;
    @(negedge clk);
    kp = '0; kr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int base_s, base_l, w;
  logic [NK-1:0] rp, rr;

  initial begin
    eif.evt_ready = 1'b1;
    @(negedge clk);
    chk("reset_valid", eif.evt_valid, 0);
    chk("reset_key", eif.evt_key, 0);
    chk("reset_type", eif.evt_type, 0);
    chk("reset_drop", eif.drop_cnt, 0);
    rst_n = 1'b1;

    // 1: short press on key2
    step(4'b0100, 0);
    idle(19);
    step(0, 4'b0100);
    chk("s1_not_yet", eif.evt_valid, 0);
    idle(1);
    chk("s1_valid", eif.evt_valid, 1);
    chk("s1_key", eif.evt_key, 2);
    chk("s1_type", eif.evt_type, 1);
    idle(1);
    chk("s1_one_cycle", eif.evt_valid, 0);

    // 2: long hold on key0 -> LONG then 3 REPEATs, nothing on release
    step(4'b0001, 0);
    idle(114);
    step(0, 4'b0001);
    idle(5);
    chk("s2_short", n_short, 1);
    chk("s2_long", n_long, 1);
    chk("s2_repeat", n_rep, 3);
    chk("s2_rr", mrr, 1);

    // 3: simultaneous releases on keys 0,1,3 with rr at 1
    step(4'b1011, 0);
    idle(10);
    step(0, 4'b1011);
    chk("s3_empty", eif.evt_valid, 0);
    idle(1); chk("s3_first", {eif.evt_valid, eif.evt_key, eif.evt_type}, {1'b1, 2'd1, 2'b01});
    idle(1); chk("s3_second", {eif.evt_valid, eif.evt_key, eif.evt_type}, {1'b1, 2'd3, 2'b01});
    idle(1); chk("s3_third", {eif.evt_valid, eif.evt_key, eif.evt_type}, {1'b1, 2'd0, 2'b01});
    idle(1); chk("s3_done", eif.evt_valid, 0);
    chk("s3_rr", mrr, 1);

    // 4: back-pressure, full FIFO, pending slot, one drop
    eif.evt_ready = 1'b0;
    step(4'b1111, 0);
    step(0, 4'b0001); step(0, 4'b0010); step(0, 4'b0100); step(0, 4'b1000);
    idle(2);
    step(4'b0001, 0); step(0, 4'b0001);
    step(4'b0001, 0); step(0, 4'b0001);
    idle(2);
    chk("s4_drop", eif.drop_cnt, 1);
    chk("s4_head", {eif.evt_valid, eif.evt_key}, {1'b1, 2'd0});
    base_s = n_short;
    eif.evt_ready = 1'b1;
    idle(8);
    chk("s4_drained", n_short - base_s, 5);
    chk("s4_empty", eif.evt_valid, 0);

    // 5: reset with key1 held and two events queued
    eif.evt_ready = 1'b0;
    step(4'b0110, 0);
    step(0, 4'b0100);
    idle(54);
    chk("s5_head", {eif.evt_valid, eif.evt_key, eif.evt_type}, {1'b1, 2'd2, 2'b01});
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("s5_valid", eif.evt_valid, 0);
    chk("s5_drop", eif.drop_cnt, 0);
    eif.evt_ready = 1'b1;
    step(0, 4'b0010);
    idle(3);
    chk("s5_no_event", eif.evt_valid, 0);
    step(4'b1000, 0);
    step(0, 4'b1000);
    idle(1);
    chk("s5_after", {eif.evt_valid, eif.evt_key, eif.evt_type}, {1'b1, 2'd3, 2'b01});
    idle(2);

    // 6: release on the very tick that would make LONG
    base_l = n_long;
    step(4'b0100, 0);
    w = 0;
    while (!(mt[2] == LM - 1 && mtcnt == TP - 1) && w < 100) begin idle(1); w++; end
    chk("s6_align", (w < 100), 1);
    step(4'b0100, 4'b0100);
    idle(1);
    chk("s6_short", {eif.evt_valid, eif.evt_key, eif.evt_type}, {1'b1, 2'd2, 2'b01});
    idle(60);
    chk("s6_no_long", n_long - base_l, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      eif.evt_ready = ($urandom_range(3) != 0);
      for (int k = 0; k < NK; k++) begin
        rp[k] = ($urandom_range(15) == 0);
        rr[k] = ($urandom_range(39) == 0);
      end
      if (c == 1500) rst_n = 1'b0;
      step(rp, rr);
      rst_n = 1'b1;
    end
    eif.evt_ready = 1'b1;
    idle(20);
    chk("final_drain", eif.evt_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
